axi4_lite_master_rw: RTL and testbench



---
 rtl/axi4_lite_pkg.sv | 26 ++
 rtl/axi4_lite_master_rw.sv | 212 +++++++++++++++++++++
 tb/tb_axi4_lite_master_rw.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared definitions for the AXI4-Lite master blocks.
//   RESP_*   : AXI response codes.
//   state_e  : controller state encoding. DRAIN is only reachable when the
//              AXI4_LITE_MASTER_TIMEOUT_EN build option is enabled.
// No ports (package).
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RESPOND = 3'd5,
      DRAIN   = 3'd6
   } state_e;

endpackage

// File: rtl/axi4_lite_master_rw.sv
// -----------------------------------------------------------------------------
// axi4_lite_master_rw
// Turns single read/write commands into AXI4-Lite transactions, one at a time,
// and hands back one response per command.
//
// Build option: define AXI4_LITE_MASTER_TIMEOUT_EN to enable the response
// timeout (counter + DRAIN state). Without it the block waits forever for
// B/R and rsp_timeout is tied to 0.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   cmd_valid/ready           : command handshake
//   cmd_write/addr/wdata/wstrb: command contents (write=1, read=0)
//   rsp_valid/ready           : response handshake
//   rsp_rdata/resp/timeout    : read data (0 for writes), AXI code, timeout flag
//   m_axi_*                   : AXI4-Lite master channels AW, W, B, AR, R
// -----------------------------------------------------------------------------
module axi4_lite_master_rw
   import axi4_lite_pkg::*;
#(
   parameter int addr_width     = 12,
   parameter int data_width     = 32,
   parameter int timeout_cycles = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [addr_width-1:0]   cmd_addr,
   input  logic [data_width-1:0]   cmd_wdata,
   input  logic [data_width/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [data_width-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   output logic [addr_width-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [data_width-1:0]   m_axi_wdata,
   output logic [data_width/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [addr_width-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [data_width-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   localparam int StrbW = data_width / 8;

   if (!(data_width == 32 || data_width == 64 || data_width == 128) || timeout_cycles < 1) begin : g_bad_params
      $error("axi4_lite_master_rw: data_width must be 32/64/128 and timeout_cycles >= 1");
   end

   state_e                state_q, state_d;
   logic                  cmdReady_q;
   logic                  awValid_q, wValid_q, arValid_q;
   logic [addr_width-1:0] addr_q;
   logic [data_width-1:0] wdata_q;
   logic [StrbW-1:0]      wstrb_q;
   logic [data_width-1:0] rspRdata_q;
   logic [1:0]            rspResp_q;

   logic cmdAccept, awHs, wHs, arHs, bHs, rHs;
   logic bReady, rReady, addrPhaseDone, tmoFire, rspTimeout;

   assign cmdAccept     = cmd_valid & cmdReady_q;
   assign awHs          = awValid_q & m_axi_awready;
   assign wHs           = wValid_q & m_axi_wready;
   assign arHs          = arValid_q & m_axi_arready;
   assign bHs           = m_axi_bvalid & bReady;
   assign rHs           = m_axi_rvalid & rReady;
   // AW and W complete independently; either may already be done or finish now.
   assign addrPhaseDone = (~awValid_q | awHs) & (~wValid_q | wHs);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
   localparam int TmoW = $clog2(timeout_cycles + 1);

   logic [TmoW-1:0] tmoCnt_q;
   logic            isWrite_q;
   logic            rspTimeout_q;
   logic            waiting;

   assign waiting    = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_RESP);
   // Fires on the cycle the counter would reach timeout_cycles; a real
   // B/R handshake in that same cycle takes priority.
   assign tmoFire    = waiting && (tmoCnt_q == TmoW'(timeout_cycles - 1)) && !bHs && !rHs;
   // In DRAIN the late response of the abandoned transaction is swallowed.
   assign bReady     = (state_q == WR_RESP) || ((state_q == DRAIN) && isWrite_q);
   assign rReady     = (state_q == RD_RESP) || ((state_q == DRAIN) && !isWrite_q);
   assign rspTimeout = rspTimeout_q;

   // Timeout counter and the bookkeeping DRAIN needs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmoCnt_q     <= '0;
         isWrite_q    <= 1'b0;
         rspTimeout_q <= 1'b0;
      end else begin
         if (cmdAccept) begin
            tmoCnt_q     <= '0;
            isWrite_q    <= cmd_write;
            rspTimeout_q <= 1'b0;
         end else begin
            if (waiting) tmoCnt_q <= tmoCnt_q + 1'b1;
            if (tmoFire) rspTimeout_q <= 1'b1;
         end
      end
   end
`else
   assign tmoFire    = 1'b0;
   assign bReady     = (state_q == WR_RESP);
   assign rReady     = (state_q == RD_RESP);
   assign rspTimeout = 1'b0;
`endif

   // Next-state logic; a timeout overrides whatever wait state we are in.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmdAccept)     state_d = cmd_write ? WR_REQ : RD_REQ;
         WR_REQ:  if (addrPhaseDone) state_d = WR_RESP;
         WR_RESP: if (bHs)           state_d = RESPOND;
         RD_REQ:  if (arHs)          state_d = RD_RESP;
         RD_RESP: if (rHs)           state_d = RESPOND;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
         RESPOND: if (rsp_ready)     state_d = rspTimeout ? DRAIN : IDLE;
         DRAIN:   if (bHs || rHs)    state_d = IDLE;
`else
         RESPOND: if (rsp_ready)     state_d = IDLE;
`endif
         default:                    state_d = IDLE;
      endcase
      if (tmoFire) state_d = RESPOND;
   end

   // State, command capture and AXI valids. cmd_ready is registered so that it
   // stays low while reset is held and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cmdReady_q <= 1'b0;
         awValid_q  <= 1'b0;
         wValid_q   <= 1'b0;
         arValid_q  <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         state_q    <= state_d;
         cmdReady_q <= (state_d == IDLE);
         if (cmdAccept) begin
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            awValid_q <= cmd_write;
            wValid_q  <= cmd_write;
            arValid_q <= ~cmd_write;
         end else begin
            if (awHs) awValid_q <= 1'b0;
            if (wHs)  wValid_q  <= 1'b0;
            if (arHs) arValid_q <= 1'b0;
         end
      end
   end

   // Response capture; held unchanged through RESPOND until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rspRdata_q <= '0;
         rspResp_q  <= RESP_OKAY;
      end else if ((state_q == WR_RESP) && bHs) begin
         rspRdata_q <= '0;
         rspResp_q  <= m_axi_bresp;
      end else if ((state_q == RD_RESP) && rHs) begin
         rspRdata_q <= m_axi_rdata;
         rspResp_q  <= m_axi_rresp;
      end else if (tmoFire) begin
         rspRdata_q <= '0;
         rspResp_q  <= RESP_SLVERR;
      end
   end

   assign cmd_ready     = cmdReady_q;
   assign rsp_valid     = (state_q == RESPOND);
   assign rsp_rdata     = rspRdata_q;
   assign rsp_resp      = rspResp_q;
   assign rsp_timeout   = rspTimeout;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_awvalid = awValid_q;
   assign m_axi_wvalid  = wValid_q;
   assign m_axi_arvalid = arValid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_bready  = bReady;
   assign m_axi_rready  = rReady;

endmodule

// File: tb/tb_axi4_lite_master_rw.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_master_rw
// Self-checking bench for axi4_lite_master_rw. A cycle-level slave/consumer
// model lives in applyStimulus; it predicts every valid/ready and the response
// from handshake timing alone. With AXI4_LITE_MASTER_TIMEOUT_EN defined the
// late-read timeout scenario is also exercised.
// -----------------------------------------------------------------------------
module tb_axi4_lite_master_rw;

   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [SW-1:0] cmd_wstrb = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          rsp_timeout;
   logic [AW-1:0] m_axi_awaddr;
   logic [2:0]    m_axi_awprot;
   logic          m_axi_awvalid;
   logic          m_axi_awready = 1'b0;
   logic [DW-1:0] m_axi_wdata;
   logic [SW-1:0] m_axi_wstrb;
   logic          m_axi_wvalid;
   logic          m_axi_wready = 1'b0;
   logic [1:0]    m_axi_bresp = '0;
   logic          m_axi_bvalid = 1'b0;
   logic          m_axi_bready;
   logic [AW-1:0] m_axi_araddr;
   logic [2:0]    m_axi_arprot;
   logic          m_axi_arvalid;
   logic          m_axi_arready = 1'b0;
   logic [DW-1:0] m_axi_rdata = '0;
   logic [1:0]    m_axi_rresp = '0;
   logic          m_axi_rvalid = 1'b0;
   logic          m_axi_rready;

   int checks = 0;
   int errors = 0;

   axi4_lite_master_rw #(
      .addr_width     (AW),
      .data_width     (DW),
      .timeout_cycles (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_wstrb     (cmd_wstrb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .rsp_timeout   (rsp_timeout),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awprot  (m_axi_awprot),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (m_axi_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wstrb   (m_axi_wstrb),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (m_axi_wready),
      .m_axi_bresp   (m_axi_bresp),
      .m_axi_bvalid  (m_axi_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Park all slave-side and consumer inputs.
   task automatic idleInputs();
      cmd_valid     = 1'b0;
      rsp_ready     = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
   endtask

   // One full transaction against a behavioural slave. aDelay/wDelay: cycles
   // the address/data ready stays low; respDelay: extra cycles before B/R;
   // rspDelay: cycles rsp_ready stays low after rsp_valid is expected.
   task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                input logic [SW-1:0] wstrb, input int aDelay, input int wDelay,
                                input int respDelay, input logic [1:0] resp, input logic [DW-1:0] rdata,
                                input int rspDelay);
      bit awDone = 0, wDone = 0, arDone = 0, phaseDone = 0, respDone = 0, rspDone = 0;
      bit expAw, expW, expAr, expBready, expRready, expRsp;
      int respStart = 0, rspStart = 0;
      logic [DW-1:0] expRdata;
      expRdata  = wr ? '0 : rdata;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_wstrb = wstrb;
      checkOutput("cmd_ready_idle", 128'(cmd_ready), 128'(1'b1));
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 1; k < 300 && !rspDone; k++) begin
         expAw     = wr && !awDone;
         expW      = wr && !wDone;
         expAr     = !wr && !arDone;
         expBready = wr && phaseDone && !respDone;
         expRready = !wr && phaseDone && !respDone;
         expRsp    = respDone && !rspDone;
         m_axi_awready = wr && (k > aDelay);
         m_axi_wready  = wr && (k > wDelay);
         m_axi_arready = !wr && (k > aDelay);
         m_axi_bvalid  = wr && phaseDone && !respDone && (k >= respStart);
         m_axi_rvalid  = !wr && phaseDone && !respDone && (k >= respStart);
         m_axi_bresp   = resp;
         m_axi_rresp   = resp;
         m_axi_rdata   = rdata;
         rsp_ready     = expRsp && (k >= rspStart);
         // A competing command while the response waits must be ignored.
         cmd_valid     = expRsp && !rsp_ready;
         cmd_write     = ~wr;
         cmd_addr      = ~addr;
         checkOutput("awvalid", 128'(m_axi_awvalid), 128'(expAw));
         checkOutput("wvalid", 128'(m_axi_wvalid), 128'(expW));
         checkOutput("arvalid", 128'(m_axi_arvalid), 128'(expAr));
         checkOutput("bready", 128'(m_axi_bready), 128'(expBready));
         checkOutput("rready", 128'(m_axi_rready), 128'(expRready));
         checkOutput("rsp_valid", 128'(rsp_valid), 128'(expRsp));
         checkOutput("cmd_ready_busy", 128'(cmd_ready), 128'(1'b0));
         if (expAw) begin
            checkOutput("awaddr", 128'(m_axi_awaddr), 128'(addr));
            checkOutput("awprot", 128'(m_axi_awprot), 128'(3'b000));
         end
         if (expW) begin
            checkOutput("wdata", 128'(m_axi_wdata), 128'(wdata));
            checkOutput("wstrb", 128'(m_axi_wstrb), 128'(wstrb));
         end
         if (expAr) begin
            checkOutput("araddr", 128'(m_axi_araddr), 128'(addr));
            checkOutput("arprot", 128'(m_axi_arprot), 128'(3'b000));
         end
         if (expRsp) begin
            checkOutput("rsp_rdata", 128'(rsp_rdata), 128'(expRdata));
            checkOutput("rsp_resp", 128'(rsp_resp), 128'(resp));
            checkOutput("rsp_timeout", 128'(rsp_timeout), 128'(1'b0));
         end
         if (expAw && m_axi_awready) awDone = 1;
         if (expW && m_axi_wready)   wDone = 1;
         if (expAr && m_axi_arready) arDone = 1;
         if (!phaseDone && (wr ? (awDone && wDone) : arDone)) begin
            phaseDone = 1;
            respStart = k + 1 + respDelay;
         end
         if ((expBready && m_axi_bvalid) || (expRready && m_axi_rvalid)) begin
            respDone = 1;
            rspStart = k + 1 + rspDelay;
         end
         if (expRsp && rsp_ready) rspDone = 1;
         @(negedge clk);
      end
      if (!rspDone) checkOutput("txn_complete", 128'(1'b0), 128'(1'b1));
      idleInputs();
      checkOutput("cmd_ready_after_rsp", 128'(cmd_ready), 128'(1'b1));
      checkOutput("no_extra_aw", 128'(m_axi_awvalid), 128'(1'b0));
      checkOutput("no_extra_ar", 128'(m_axi_arvalid), 128'(1'b0));
      checkOutput("rsp_valid_after", 128'(rsp_valid), 128'(1'b0));
   endtask

   // Reset pulse while a write's AW is still waiting for awready.
   task automatic applyMidReset();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 12'h0A4;
      cmd_wdata = 32'h55AA_33CC;
      cmd_wstrb = 4'hF;
      checkOutput("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("rst_aw_pending", 128'(m_axi_awvalid), 128'(1'b1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_aw_async", 128'(m_axi_awvalid), 128'(1'b0));
      checkOutput("rst_w_async", 128'(m_axi_wvalid), 128'(1'b0));
      checkOutput("rst_cmd_ready_low", 128'(cmd_ready), 128'(1'b0));
      checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
      @(negedge clk);
      checkOutput("rst_hold_cmd_ready", 128'(cmd_ready), 128'(1'b0));
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_release_cmd_ready", 128'(cmd_ready), 128'(1'b1));
      checkOutput("rst_release_rsp_valid", 128'(rsp_valid), 128'(1'b0));
      checkOutput("rst_release_aw", 128'(m_axi_awvalid), 128'(1'b0));
   endtask

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
   // Read whose R arrives long after the timeout: the timeout response comes
   // first, the late R is swallowed in DRAIN, then the block reopens.
   task automatic applyTimeoutRead();
      localparam int RespAt = TMO + 1;
      localparam int LateR  = 22;
      bit rDone = 0, expRready, expRsp;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 12'h040;
      checkOutput("tmo_cmd_ready", 128'(cmd_ready), 128'(1'b1));
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 1; k < 60 && !rDone; k++) begin
         expRsp    = (k == RespAt);
         expRready = ((k >= 2) && (k <= TMO)) || ((k > RespAt) && !rDone);
         m_axi_arready = 1'b1;
         m_axi_rvalid  = (k >= LateR);
         m_axi_rdata   = 32'hCAFE_F00D;
         m_axi_rresp   = 2'b00;
         rsp_ready     = expRsp;
         checkOutput("tmo_arvalid", 128'(m_axi_arvalid), 128'(k == 1));
         checkOutput("tmo_rready", 128'(m_axi_rready), 128'(expRready));
         checkOutput("tmo_rsp_valid", 128'(rsp_valid), 128'(expRsp));
         checkOutput("tmo_cmd_ready_busy", 128'(cmd_ready), 128'(1'b0));
         if (expRsp) begin
            checkOutput("tmo_flag", 128'(rsp_timeout), 128'(1'b1));
            checkOutput("tmo_resp", 128'(rsp_resp), 128'(2'b10));
            checkOutput("tmo_rdata", 128'(rsp_rdata), 128'(0));
         end
         if (expRready && m_axi_rvalid && (k > RespAt)) rDone = 1;
         @(negedge clk);
      end
      if (!rDone) checkOutput("tmo_drain_done", 128'(1'b0), 128'(1'b1));
      idleInputs();
      checkOutput("tmo_cmd_ready_after", 128'(cmd_ready), 128'(1'b1));
      checkOutput("tmo_rsp_valid_after", 128'(rsp_valid), 128'(1'b0));
   endtask
`endif

   // Hard stop in case something stalls outside the bounded loops.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed cases, reset mid-flight, optional timeout, random.
   initial begin
      idleInputs();
      #1;
      checkOutput("reset_cmd_ready", 128'(cmd_ready), 128'(1'b0));
      checkOutput("reset_rsp_valid", 128'(rsp_valid), 128'(1'b0));
      checkOutput("reset_rsp_resp", 128'(rsp_resp), 128'(2'b00));
      checkOutput("reset_awvalid", 128'(m_axi_awvalid), 128'(1'b0));
      checkOutput("reset_arvalid", 128'(m_axi_arvalid), 128'(1'b0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("cmd_ready_after_reset", 128'(cmd_ready), 128'(1'b1));

      applyStimulus(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0);
      applyStimulus(1'b1, 12'h024, 32'hA5A50F0F, 4'h3, 3, 0, 1, 2'b10, 32'h0, 1);
      applyStimulus(1'b0, 12'h018, 32'h0, 4'h0, 1, 0, 2, 2'b11, 32'h12345678, 0);
      applyStimulus(1'b1, 12'h100, 32'h00000001, 4'h1, 0, 2, 0, 2'b11, 32'h0, 5);
      applyStimulus(1'b0, 12'h200, 32'h0, 4'h0, 0, 0, 0, 2'b10, 32'h0BADF00D, 5);

      applyMidReset();

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      applyTimeoutRead();
`endif

      for (int i = 0; i < 25; i++) begin
         applyStimulus(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 3)), 2'($urandom), $urandom,
                       int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
